// File: rtl/spi_cfg_write_arbiter.sv
// Two-requester round-robin arbiter that sends each granted register write as one
// 16-bit SPI mode-0 frame {1'b1, addr[6:0], data[7:0]}, MSB first.
module spi_cfg_write_arbiter #(
    parameter int HALF_DIV = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int GAP      = 2,
    parameter int MAX_ADDR = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [6:0] addr0,
    input  logic [7:0] data0,
    output logic       ack0,
    output logic       err0,
    input  logic       req1,
    input  logic [6:0] addr1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       err1,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_copi,
    output logic       busy
);
    localparam int CW = 16;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t          r_state, w_state_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [4:0]      r_bit, w_bit_next;
    logic [15:0]     r_shift, w_shift_next;
    logic            r_owner, w_owner_next;
    logic            r_rr, w_rr_next;
    logic            r_cs_n, w_cs_n_next;
    logic            r_sclk, w_sclk_next;
    logic            r_copi, w_copi_next;
    logic            r_ack0, w_ack0_next;
    logic            r_ack1, w_ack1_next;
    logic            r_err0, w_err0_next;
    logic            r_err1, w_err1_next;
    logic            r_busy;

    logic            w_grant;
    logic            w_sel;
    logic [6:0]      w_addr;
    logic [7:0]      w_data;
    logic [15:0]     w_word;

    // Hold off a new grant while an ack is out, so a requester that just saw its
    // rejection ack is not immediately granted again on the same held request.
    assign w_grant = (req0 | req1) & ~(r_ack0 | r_ack1);
    assign w_sel   = (req0 & req1) ? r_rr : req1;
    assign w_addr  = w_sel ? addr1 : addr0;
    assign w_data  = w_sel ? data1 : data0;
    assign w_word  = {1'b1, w_addr, w_data};

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_owner_next = r_owner;
        w_rr_next    = r_rr;
        w_cs_n_next  = r_cs_n;
        w_sclk_next  = r_sclk;
        w_copi_next  = r_copi;
        w_ack0_next  = 1'b0;
        w_ack1_next  = 1'b0;
        w_err0_next  = 1'b0;
        w_err1_next  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_rr_next    = ~w_sel;
                    w_owner_next = w_sel;
                    if (int'(w_addr) > MAX_ADDR) begin
                        w_ack0_next = ~w_sel;
                        w_err0_next = ~w_sel;
                        w_ack1_next = w_sel;
                        w_err1_next = w_sel;
                    end else begin
                        w_state_next = S_SETUP;
                        w_shift_next = w_word;
                        w_cs_n_next  = 1'b0;
                        w_sclk_next  = 1'b0;
                        w_copi_next  = w_word[15];
                        w_cnt_next   = '0;
                    end
                end
            end
            S_SETUP: begin
                if (r_cnt == CW'(CS_SETUP - 1)) begin
                    w_state_next = S_SHIFT;
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    w_sclk_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_SHIFT: begin
                if (r_cnt == CW'(HALF_DIV - 1)) begin
                    w_cnt_next  = '0;
                    w_sclk_next = ~r_sclk;
                    // copi only moves on the falling edge so it is settled at every rise
                    if (r_sclk) begin
                        if (r_bit == 5'd15) begin
                            w_state_next = S_HOLD;
                        end else begin
                            w_copi_next  = r_shift[14];
                            w_shift_next = {r_shift[14:0], 1'b0};
                            w_bit_next   = r_bit + 5'd1;
                        end
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_HOLD: begin
                if (r_cnt == CW'(CS_HOLD - 1)) begin
                    w_state_next = S_GAP;
                    w_cnt_next   = '0;
                    w_cs_n_next  = 1'b1;
                    w_copi_next  = 1'b0;
                    w_ack0_next  = ~r_owner;
                    w_ack1_next  = r_owner;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_GAP: begin
                // the ack/cs_n-rise cycle is the first of GAP+1 cycles spent here
                if (r_cnt == CW'(GAP)) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_owner <= 1'b0;
            r_rr    <= 1'b0;
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b0;
            r_copi  <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_owner <= w_owner_next;
            r_rr    <= w_rr_next;
            r_cs_n  <= w_cs_n_next;
            r_sclk  <= w_sclk_next;
            r_copi  <= w_copi_next;
            r_ack0  <= w_ack0_next;
            r_ack1  <= w_ack1_next;
            r_err0  <= w_err0_next;
            r_err1  <= w_err1_next;
            r_busy  <= (w_state_next != S_IDLE);
        end
    end

    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign err0     = r_err0;
    assign err1     = r_err1;
    assign spi_cs_n = r_cs_n;
    assign spi_sclk = r_sclk;
    assign spi_copi = r_copi;
    assign busy     = r_busy;
endmodule

// File: tb/tb_spi_cfg_write_arbiter.sv
// Directed bench: instance 0 uses default timing, instance 1 uses HALF_DIV=CS_SETUP=CS_HOLD=1.
module tb_spi_cfg_write_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] req0, req1, ack0, ack1, err0, err1, cs_n, sclk, copi, busy;
    logic [6:0] addr0 [2];
    logic [6:0] addr1 [2];
    logic [7:0] data0 [2];
    logic [7:0] data1 [2];

    int n_vec = 0;
    int n_bad = 0;

    spi_cfg_write_arbiter u_a (
        .clk(clk), .rst_n(rst_n),
        .req0(req0[0]), .addr0(addr0[0]), .data0(data0[0]), .ack0(ack0[0]), .err0(err0[0]),
        .req1(req1[0]), .addr1(addr1[0]), .data1(data1[0]), .ack1(ack1[0]), .err1(err1[0]),
        .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]), .spi_copi(copi[0]), .busy(busy[0])
    );

    spi_cfg_write_arbiter #(.HALF_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req0(req0[1]), .addr0(addr0[1]), .data0(data0[1]), .ack0(ack0[1]), .err0(err0[1]),
        .req1(req1[1]), .addr1(addr1[1]), .data1(data1[1]), .ack1(ack1[1]), .err1(err1[1]),
        .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]), .spi_copi(copi[1]), .busy(busy[1])
    );

    // Per-instance SPI monitor, sampling on the falling clk edge.
    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
        int nb = 0, low = 0, high = 0, last_low = 0, last_gap = 0, last_nb = 0;
        int frames = 0, falls = 0, stab = 0, ack_rise = 0, a0n = 0, a1n = 0, e1n = 0, both = 0;
        logic [15:0] sh = '0, last_word = '0;
        logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0;

        always @(negedge clk) begin
            if (!rst_n) begin
                nb <= 0; low <= 0; sh <= '0;
                prev_cs <= 1'b1; prev_sclk <= 1'b0; prev_copi <= 1'b0;
            end else begin
                if (!cs_n[gi] && prev_cs) begin
                    last_gap <= high; low <= 1; sh <= '0; falls <= falls + 1;
                end else if (!cs_n[gi]) begin
                    low <= low + 1;
                end
                if (!cs_n[gi] && sclk[gi] && !prev_sclk) begin
                    sh <= {sh[14:0], copi[gi]}; nb <= nb + 1;
                end
                if (!cs_n[gi] && sclk[gi] && copi[gi] !== prev_copi) stab <= stab + 1;
                if (cs_n[gi] && !prev_cs) begin
                    last_word <= sh; last_low <= low; last_nb <= nb; nb <= 0;
                    frames <= frames + 1; high <= 1;
                    if (ack0[gi] | ack1[gi]) ack_rise <= ack_rise + 1;
                end else if (cs_n[gi]) begin
                    high <= high + 1;
                end
                if (ack0[gi]) a0n <= a0n + 1;
                if (ack1[gi]) a1n <= a1n + 1;
                if (err1[gi]) e1n <= e1n + 1;
                if (ack0[gi] && ack1[gi]) both <= both + 1;
                prev_cs <= cs_n[gi]; prev_sclk <= sclk[gi]; prev_copi <= copi[gi];
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input int inst, input bit which, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (((which ? ack1[inst] : ack0[inst]) !== 1'b1) && n < 400);
        chk(tag, {31'd0, which ? ack1[inst] : ack0[inst]}, 32'd1);
    endtask

    int a_save, f_save, fl_save, n;

    initial begin
        rst_n = 1'b0;
        req0 = '0; req1 = '0;
        for (int i = 0; i < 2; i++) begin
            addr0[i] = '0; addr1[i] = '0; data0[i] = '0; data1[i] = '0;
        end
        repeat (3) tick();
        chk("rst_cs_n", {31'd0, cs_n[0]}, 1);
        chk("rst_sclk", {31'd0, sclk[0]}, 0);
        chk("rst_copi", {31'd0, copi[0]}, 0);
        chk("rst_ack0", {31'd0, ack0[0]}, 0);
        chk("rst_err0", {31'd0, err0[0]}, 0);
        chk("rst_ack1", {31'd0, ack1[0]}, 0);
        chk("rst_err1", {31'd0, err1[0]}, 0);
        chk("rst_busy", {31'd0, busy[0]}, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // single write 0x02 <- 0xA5
        addr0[0] = 7'h02; data0[0] = 8'hA5; req0[0] = 1'b1;
        tick();
        chk("sw_busy", {31'd0, busy[0]}, 1);
        chk("sw_cs_low", {31'd0, cs_n[0]}, 0);
        chk("sw_copi_b15", {31'd0, copi[0]}, 1);
        chk("sw_sclk_setup", {31'd0, sclk[0]}, 0);
        wait_ack(0, 1'b0, "sw_ack0");
        chk("sw_err0", {31'd0, err0[0]}, 0);
        chk("sw_cs_rise_with_ack", {31'd0, cs_n[0]}, 1);
        chk("sw_ack_on_rise", g_mon[0].ack_rise, 1);
        chk("sw_word", {16'd0, g_mon[0].last_word}, 32'h82A5);
        chk("sw_cs_low_len", g_mon[0].last_low, 66);
        chk("sw_rising_edges", g_mon[0].last_nb, 16);
        req0[0] = 1'b0;
        tick();
        chk("sw_ack0_single", {31'd0, ack0[0]}, 0);
        chk("sw_ack0_count", g_mon[0].a0n, 1);

        // contention from a fresh reset: requester 0 first
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        addr0[0] = 7'h00; data0[0] = 8'h11; req0[0] = 1'b1;
        addr1[0] = 7'h04; data1[0] = 8'h22; req1[0] = 1'b1;
        wait_ack(0, 1'b0, "ct_ack0_first");
        chk("ct_word0", {16'd0, g_mon[0].last_word}, 32'h8011);
        // requester 0 re-presents at once: both pending again, requester 1 is due
        addr0[0] = 7'h01; data0[0] = 8'h33;
        wait_ack(0, 1'b1, "ct_ack1");
        chk("ct_word1", {16'd0, g_mon[0].last_word}, 32'h8422);
        req1[0] = 1'b0;
        wait_ack(0, 1'b0, "ct_ack0_second");
        chk("ct_word2", {16'd0, g_mon[0].last_word}, 32'h8133);
        req0[0] = 1'b0;

        // out-of-range address on requester 1
        repeat (6) tick();
        f_save = g_mon[0].frames; fl_save = g_mon[0].falls;
        addr1[0] = 7'h05; data1[0] = 8'h77; req1[0] = 1'b1;
        tick();
        chk("inv_ack1_t1", {31'd0, ack1[0]}, 1);
        chk("inv_err1_t1", {31'd0, err1[0]}, 1);
        chk("inv_cs_high", {31'd0, cs_n[0]}, 1);
        chk("inv_busy", {31'd0, busy[0]}, 0);
        req1[0] = 1'b0;
        tick();
        chk("inv_ack1_single", {31'd0, ack1[0]}, 0);
        repeat (4) tick();
        chk("inv_no_cs_fall", g_mon[0].falls, fl_save);
        chk("inv_err1_count", g_mon[0].e1n, 1);
        addr0[0] = 7'h03; data0[0] = 8'h5A; req0[0] = 1'b1;
        wait_ack(0, 1'b0, "inv_next_ack0");
        chk("inv_next_word", {16'd0, g_mon[0].last_word}, 32'h835A);
        chk("inv_frames", g_mon[0].frames, f_save + 1);
        req0[0] = 1'b0;

        // back-to-back on requester 0
        tick();
        addr0[0] = 7'h04; data0[0] = 8'hC3; req0[0] = 1'b1;
        a_save = g_mon[0].a0n;
        wait_ack(0, 1'b0, "b2b_ack_a");
        chk("b2b_word_a", {16'd0, g_mon[0].last_word}, 32'h84C3);
        wait_ack(0, 1'b0, "b2b_ack_b");
        chk("b2b_word_b", {16'd0, g_mon[0].last_word}, 32'h84C3);
        chk("b2b_gap_ge4", {31'd0, g_mon[0].last_gap >= 4}, 1);
        chk("b2b_ack_count", g_mon[0].a0n, a_save + 2);
        req0[0] = 1'b0;

        // reset after 7 rising edges, then full resend
        repeat (4) tick();
        addr0[0] = 7'h01; data0[0] = 8'h0F; req0[0] = 1'b1;
        a_save = g_mon[0].a0n;
        n = 0;
        while (g_mon[0].nb < 7 && n < 300) begin
            tick();
            n++;
        end
        chk("rmf_reached_7", g_mon[0].nb, 7);
        rst_n = 1'b0;
        #1;
        chk("rmf_cs_n", {31'd0, cs_n[0]}, 1);
        chk("rmf_sclk", {31'd0, sclk[0]}, 0);
        chk("rmf_ack0", {31'd0, ack0[0]}, 0);
        chk("rmf_busy", {31'd0, busy[0]}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_ack(0, 1'b0, "rmf_ack0_resend");
        chk("rmf_word", {16'd0, g_mon[0].last_word}, 32'h810F);
        chk("rmf_edges", g_mon[0].last_nb, 16);
        chk("rmf_single_ack", g_mon[0].a0n, a_save + 1);
        req0[0] = 1'b0;

        // fast timing instance
        tick();
        addr0[1] = 7'h03; data0[1] = 8'hFF; req0[1] = 1'b1;
        wait_ack(1, 1'b0, "fast_ack0");
        chk("fast_word", {16'd0, g_mon[1].last_word}, 32'h83FF);
        chk("fast_cs_low_len", g_mon[1].last_low, 33);
        chk("fast_edges", g_mon[1].last_nb, 16);
        chk("fast_copi_stable", g_mon[1].stab, 0);
        req0[1] = 1'b0;
        tick();

        chk("copi_stable_default", g_mon[0].stab, 0);
        chk("no_simultaneous_acks", g_mon[0].both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
